// File: rtl/cordic_rotation_sequencer.sv
// Iterative rotation-mode CORDIC: one shared shift/add X/Y/Z datapath, stepped
// ITERATIONS times per job. The results register only when the job completes.
module cordic_rotation_sequencer #(
    parameter int ITERATIONS = 16
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    input  logic [31:0] x_in,
    input  logic [31:0] y_in,
    input  logic [31:0] angle_in,
    output logic        ready,
    output logic        busy,
    output logic        done,
    output logic [31:0] x_out,
    output logic [31:0] y_out,
    output logic [31:0] z_out,
    output logic [4:0]  iteration
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [4:0] LAST_ITER = 5'(ITERATIONS - 1);

    state_t             state_q, state_d;
    logic signed [31:0] x_q, x_d, y_q, y_d, z_q, z_d;
    logic [31:0]        xo_q, xo_d, yo_q, yo_d, zo_q, zo_d;
    logic [4:0]         i_q, i_d;

    logic signed [31:0] x_shift, y_shift, atan_i;
    logic signed [31:0] x_step, y_step, z_step;

    // round(atan(2^-i) * 2^30); from i=11 onward the table equals 2^(30-i)
    function automatic logic signed [31:0] atan_lut(input logic [4:0] idx);
        case (idx)
            5'd0:    atan_lut = 32'sd843314857;
            5'd1:    atan_lut = 32'sd497837830;
            5'd2:    atan_lut = 32'sd263043837;
            5'd3:    atan_lut = 32'sd133525159;
            5'd4:    atan_lut = 32'sd67021687;
            5'd5:    atan_lut = 32'sd33543516;
            5'd6:    atan_lut = 32'sd16775851;
            5'd7:    atan_lut = 32'sd8388437;
            5'd8:    atan_lut = 32'sd4194283;
            5'd9:    atan_lut = 32'sd2097149;
            5'd10:   atan_lut = 32'sd1048576;
            5'd11:   atan_lut = 32'sd524288;
            5'd12:   atan_lut = 32'sd262144;
            5'd13:   atan_lut = 32'sd131072;
            5'd14:   atan_lut = 32'sd65536;
            5'd15:   atan_lut = 32'sd32768;
            5'd16:   atan_lut = 32'sd16384;
            5'd17:   atan_lut = 32'sd8192;
            5'd18:   atan_lut = 32'sd4096;
            5'd19:   atan_lut = 32'sd2048;
            5'd20:   atan_lut = 32'sd1024;
            5'd21:   atan_lut = 32'sd512;
            5'd22:   atan_lut = 32'sd256;
            5'd23:   atan_lut = 32'sd128;
            default: atan_lut = 32'sd0;
        endcase
    endfunction

    assign x_shift = x_q >>> i_q;
    assign y_shift = y_q >>> i_q;
    assign atan_i  = atan_lut(i_q);

    // Negative residual angle (sign bit set) rotates clockwise; zero counts as positive.
    always_comb begin
        if (z_q[31]) begin
            x_step = x_q + y_shift;
            y_step = y_q - x_shift;
            z_step = z_q + atan_i;
        end else begin
            x_step = x_q - y_shift;
            y_step = y_q + x_shift;
            z_step = z_q - atan_i;
        end
    end

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        z_d     = z_q;
        i_d     = i_q;
        xo_d    = xo_q;
        yo_d    = yo_q;
        zo_d    = zo_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    x_d     = x_in;
                    y_d     = y_in;
                    z_d     = angle_in;
                    i_d     = 5'd0;
                    state_d = RUN;
                end
            end
            RUN: begin
                x_d = x_step;
                y_d = y_step;
                z_d = z_step;
                i_d = i_q + 5'd1;
                if (i_q == LAST_ITER) begin
                    i_d     = 5'd0;
                    xo_d    = x_step;
                    yo_d    = y_step;
                    zo_d    = z_step;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q <= IDLE;
            x_q     <= '0;
            y_q     <= '0;
            z_q     <= '0;
            i_q     <= '0;
            xo_q    <= '0;
            yo_q    <= '0;
            zo_q    <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            z_q     <= z_d;
            i_q     <= i_d;
            xo_q    <= xo_d;
            yo_q    <= yo_d;
            zo_q    <= zo_d;
        end
    end

    assign ready     = (state_q == IDLE);
    assign busy      = (state_q == RUN);
    assign done      = (state_q == DONE);
    assign x_out     = xo_q;
    assign y_out     = yo_q;
    assign z_out     = zo_q;
    assign iteration = i_q;

endmodule

// File: tb/tb_cordic_rotation_sequencer.sv
// Scoreboard bench for cordic_rotation_sequencer: accepted jobs are queued with a
// real-valued expected rotation and retired against each done pulse.
module tb_cordic_rotation_sequencer;

    localparam int     N      = 16;
    localparam longint TOL    = 65536;
    localparam longint HALFPI = 1686629713;

    logic        clock    = 1'b0;
    logic        reset_n  = 1'b0;
    logic        start    = 1'b0;
    logic [31:0] x_in     = '0;
    logic [31:0] y_in     = '0;
    logic [31:0] angle_in = '0;
    logic        ready, busy, done;
    logic [31:0] x_out, y_out, z_out;
    logic [4:0]  iteration;

    cordic_rotation_sequencer #(.ITERATIONS(N)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .start     (start),
        .x_in      (x_in),
        .y_in      (y_in),
        .angle_in  (angle_in),
        .ready     (ready),
        .busy      (busy),
        .done      (done),
        .x_out     (x_out),
        .y_out     (y_out),
        .z_out     (z_out),
        .iteration (iteration)
    );

    always #5 clock = ~clock;

    typedef struct {
        longint ex;
        longint ey;
        longint ztol;
        int     t0;
    } job_t;

    job_t        sb_q[$];
    job_t        push_j, pop_j;
    int          checks    = 0;
    int          errors    = 0;
    int          ncyc      = 0;
    int          last_done = 0;
    int          done_gap  = 0;
    bit          have_last = 1'b0;
    logic [31:0] last_x, last_y, last_z;
    longint      cur_ztol  = 32832;
    real         kgain     = 1.0;
    real         th, xr, yr;

    task automatic check(input string tag, input longint obs, input longint exp,
                         input longint tol = 0);
        checks++;
        if (obs > exp + tol || obs < exp - tol) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (tolerance %0d) at cycle %0d",
                     tag, obs, exp, tol, ncyc);
        end
    endtask

    // Monitor on the falling edge: retire results, enforce hold, enqueue accepted jobs.
    always @(negedge clock) begin
        ncyc++;
        if (!reset_n) begin
            sb_q.delete();
            have_last = 1'b0;
        end else begin
            if (done) begin
                check("done_ready_low", longint'(ready), 0);
                check("done_busy_low", longint'(busy), 0);
                if (sb_q.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    pop_j = sb_q.pop_front();
                    check("x_out", longint'($signed(x_out)), pop_j.ex, TOL);
                    check("y_out", longint'($signed(y_out)), pop_j.ey, TOL);
                    check("z_out", longint'($signed(z_out)), 0, pop_j.ztol);
                    check("latency", longint'(ncyc - pop_j.t0), N + 1);
                    $display("job done: x=%0d y=%0d z=%0d exp_x=%0d exp_y=%0d",
                             $signed(x_out), $signed(y_out), $signed(z_out),
                             pop_j.ex, pop_j.ey);
                end
                done_gap  = ncyc - last_done;
                last_done = ncyc;
                last_x    = x_out;
                last_y    = y_out;
                last_z    = z_out;
                have_last = 1'b1;
            end else if (have_last) begin
                check("x_hold", longint'(x_out), longint'(last_x));
                check("y_hold", longint'(y_out), longint'(last_y));
                check("z_hold", longint'(z_out), longint'(last_z));
            end
            if (ready && start) begin
                th          = real'($signed(angle_in)) / 1073741824.0;
                xr          = real'($signed(x_in));
                yr          = real'($signed(y_in));
                push_j.ex   = longint'(kgain * (xr * $cos(th) - yr * $sin(th)));
                push_j.ey   = longint'(kgain * (yr * $cos(th) + xr * $sin(th)));
                push_j.ztol = cur_ztol;
                push_j.t0   = ncyc;
                sb_q.push_back(push_j);
            end
        end
    end

    task automatic run_job(input int xv, input int yv, input int av);
        @(posedge clock); #1;
        start    = 1'b1;
        x_in     = xv;
        y_in     = yv;
        angle_in = av;
        @(posedge clock); #1;
        start    = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        for (int k = 0; k < 4 * N; k++) begin
            if (done) return;
            @(posedge clock); #1;
        end
        check(tag, 0, 1);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_ready"}, longint'(ready), 1);
        check({tag, "_busy"}, longint'(busy), 0);
        check({tag, "_done"}, longint'(done), 0);
        check({tag, "_iter"}, longint'(iteration), 0);
        check({tag, "_x"}, longint'(x_out), 0);
        check({tag, "_y"}, longint'(y_out), 0);
        check({tag, "_z"}, longint'(z_out), 0);
    endtask

    initial begin
        for (int i = 0; i < N; i++) kgain = kgain * $sqrt(1.0 + 2.0 ** (-2.0 * i));

        repeat (3) @(posedge clock);
        @(negedge clock);
        check_reset_state("por");
        @(posedge clock); #1;
        reset_n = 1'b1;

        // Zero rotation: x must return to 1.0 after the CORDIC gain
        cur_ztol = 32832;
        run_job(652032874, 0, 0);
        wait_done("zero_timeout");
        check("zero_x_spec", longint'($signed(x_out)), 1073741824, TOL);
        check("zero_y_spec", longint'($signed(y_out)), 0, TOL);

        // pi/4
        cur_ztol = 32768;
        run_job(652032874, 0, 843314857);
        wait_done("pi4_timeout");
        check("pi4_x_spec", longint'($signed(x_out)), 759250125, TOL);
        check("pi4_y_spec", longint'($signed(y_out)), 759250125, TOL);
        check("pi4_z_spec", longint'($signed(z_out)), 0, 32768);

        // Negative angle: first micro-rotation must add atan_0 and cancel z exactly
        cur_ztol = 32832;
        run_job(652032874, 0, -843314857);
        check("neg_iter0", longint'(iteration), 0);
        check("neg_busy", longint'(busy), 1);
        @(posedge clock); #1;
        check("neg_iter1", longint'(iteration), 1);
        check("neg_z_after_i0", longint'($signed(dut.z_q)), 0);
        wait_done("neg_timeout");
        check("neg_y_spec", longint'($signed(y_out)), -759250125, TOL);

        // Reset held 3 cycles mid-RUN aborts the job without a done pulse
        run_job(652032874, 0, 500000000);
        repeat (4) begin @(posedge clock); #1; end
        reset_n = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        reset_n = 1'b1;
        @(negedge clock);
        check_reset_state("rst_rel");
        repeat (2 * N) @(posedge clock);
        #1;
        check("rst_no_job_busy", longint'(busy), 0);

        // Start pulses during RUN and DONE are ignored
        run_job(652032874, 0, 400000000);
        repeat (3) begin @(posedge clock); #1; end
        start    = 1'b1;
        x_in     = 123;
        angle_in = -5;
        @(posedge clock); #1;
        start    = 1'b0;
        wait_done("hs_a_timeout");
        start    = 1'b1;
        angle_in = 77;
        @(posedge clock); #1;
        start    = 1'b0;
        check("hs_idle_after_done", longint'(ready), 1);
        repeat (5) begin @(posedge clock); #1; end
        check("hs_pulses_ignored", longint'(busy), 0);

        // start held across DONE: next job loads on the IDLE cycle
        @(posedge clock); #1;
        start    = 1'b1;
        x_in     = 652032874;
        y_in     = 0;
        angle_in = 300000000;
        wait_done("b2b_first_timeout");
        angle_in = -600000000;
        @(posedge clock); #1;
        @(posedge clock); #1;
        start    = 1'b0;
        check("b2b_reloaded", longint'(busy), 1);
        wait_done("b2b_second_timeout");
        @(negedge clock); #1;
        check("b2b_done_gap", longint'(done_gap), N + 2);

        // Random sweep against the real-valued model
        cur_ztol = 32832;
        for (int n = 0; n < 1000; n++) begin
            int av, xv, yv;
            av = int'(longint'($urandom_range(32'(2 * HALFPI))) - HALFPI);
            xv = int'($urandom_range(1288490188)) - 644245094;
            yv = int'($urandom_range(1288490188)) - 644245094;
            run_job(xv, yv, av);
            wait_done("sweep_timeout");
        end

        repeat (4) @(posedge clock);
        #1;
        check("scoreboard_empty", longint'(sb_q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
